// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: ID-side instruction fields, forwarding sources, flush,
// and the EX-side operand/control outputs with their valid/ready handshake.
interface alu_issue_stage_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        alu_op;
  logic [2:0]        funct3;
  logic              funct7_5;
  logic              alu_src;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] imm;
  logic              exmem_regwrite;
  logic [REG_AW-1:0] exmem_rd;
  logic [DATA_W-1:0] exmem_result;
  logic              memwb_regwrite;
  logic [REG_AW-1:0] memwb_rd;
  logic [DATA_W-1:0] memwb_result;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [3:0]        ALU_control;
  logic              illegal_op;

  // Issue stage side.
  modport slave (
    input  in_valid, alu_op, funct3, funct7_5, alu_src, rs1_addr, rs2_addr,
           rs1_data, rs2_data, imm, exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result, flush, out_ready,
    output in_ready, out_valid, data1, data2, ALU_control, illegal_op
  );

  // Pipeline / environment side.
  modport master (
    output in_valid, alu_op, funct3, funct7_5, alu_src, rs1_addr, rs2_addr,
           rs1_data, rs2_data, imm, exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result, flush, out_ready,
    input  in_ready, out_valid, data1, data2, ALU_control, illegal_op
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID->EX issue register with ALU-control decode, operand forwarding and a
// one-entry skid buffer behind a valid/ready handshake.
// Optional feature macro: FORWARDING_EN (EX/MEM and MEM/WB operand forwarding).
// Without it, operands come only from the register file / immediate.
module alu_issue_stage #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 5
) (
  input logic               clk,
  input logic               reset,
  alu_issue_stage_if.slave  bus
);

  localparam logic [3:0] CtrlAnd = 4'b0000;
  localparam logic [3:0] CtrlOr  = 4'b0001;
  localparam logic [3:0] CtrlAdd = 4'b0010;
  localparam logic [3:0] CtrlSub = 4'b0110;
  localparam logic [3:0] CtrlBad = 4'b1111;

  typedef struct packed {
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [3:0]        ctrl;
    logic              illegal;
  } entry_t;

  entry_t out_q, out_d, skid_q, skid_d, new_entry;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;

  logic              in_ready;
  logic              accept;
  logic              consume;
  logic [3:0]        ctrl_dec;
  logic              illegal_dec;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2_reg;

  // Decode ALUOp/funct3/funct7[5] into the ALU control code.
  always_comb begin
    ctrl_dec    = CtrlBad;
    illegal_dec = 1'b1;
    unique case (bus.alu_op)
      2'b00: begin
        ctrl_dec    = CtrlAdd;
        illegal_dec = 1'b0;
      end
      2'b01: begin
        ctrl_dec    = CtrlSub;
        illegal_dec = 1'b0;
      end
      2'b10, 2'b11: begin
        case (bus.funct3)
          3'b000: begin
            // funct7[5] selects SUB only for R-type.
            ctrl_dec    = (bus.alu_op == 2'b10 && bus.funct7_5) ? CtrlSub : CtrlAdd;
            illegal_dec = 1'b0;
          end
          3'b111: begin
            ctrl_dec    = CtrlAnd;
            illegal_dec = 1'b0;
          end
          3'b110: begin
            ctrl_dec    = CtrlOr;
            illegal_dec = 1'b0;
          end
          default: begin
            ctrl_dec    = CtrlBad;
            illegal_dec = 1'b1;
          end
        endcase
      end
      default: begin
        ctrl_dec    = CtrlBad;
        illegal_dec = 1'b1;
      end
    endcase
  end

`ifdef FORWARDING_EN
  // Operand forwarding; the younger EX/MEM result wins over MEM/WB.
  always_comb begin
    op1     = bus.rs1_data;
    op2_reg = bus.rs2_data;
    if (bus.exmem_regwrite && bus.exmem_rd != '0 && bus.exmem_rd == bus.rs1_addr) begin
      op1 = bus.exmem_result;
    end else if (bus.memwb_regwrite && bus.memwb_rd != '0 && bus.memwb_rd == bus.rs1_addr) begin
      op1 = bus.memwb_result;
    end
    if (bus.exmem_regwrite && bus.exmem_rd != '0 && bus.exmem_rd == bus.rs2_addr) begin
      op2_reg = bus.exmem_result;
    end else if (bus.memwb_regwrite && bus.memwb_rd != '0 && bus.memwb_rd == bus.rs2_addr) begin
      op2_reg = bus.memwb_result;
    end
  end
`else
  // Register-file operands only; forwarding inputs are intentionally ignored.
  always_comb begin
    op1     = bus.rs1_data;
    op2_reg = bus.rs2_data;
  end

  logic unused_fwd;
  assign unused_fwd = ^{bus.rs1_addr, bus.rs2_addr, bus.exmem_regwrite, bus.exmem_rd,
                        bus.exmem_result, bus.memwb_regwrite, bus.memwb_rd,
                        bus.memwb_result};
`endif

  // Assemble the entry captured at accept time.
  always_comb begin
    new_entry.d1      = op1;
    new_entry.d2      = bus.alu_src ? bus.imm : op2_reg;
    new_entry.ctrl    = ctrl_dec;
    new_entry.illegal = illegal_dec;
  end

  assign in_ready = ~skid_valid_q;
  assign accept   = bus.in_valid & in_ready & ~bus.flush;
  assign consume  = out_valid_q & bus.out_ready;

  // Next state for output register and skid entry; skid is only ever full
  // while the output register is full, so the two stay in FIFO order.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || consume) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = new_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.data1       = out_q.d1;
  assign bus.data2       = out_q.d2;
  assign bus.ALU_control = out_q.ctrl;
  assign bus.illegal_op  = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

`ifdef FORWARDING_EN
  localparam bit FwdOn = 1'b1;
`else
  localparam bit FwdOn = 1'b0;
`endif

  alu_issue_stage_if #(.DATA_W(8), .REG_AW(5)) bus ();

  alu_issue_stage #(.DATA_W(8), .REG_AW(5)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid       = 1'b0;
    bus.flush          = 1'b0;
    bus.exmem_regwrite = 1'b0;
    bus.memwb_regwrite = 1'b0;
    bus.exmem_rd       = '0;
    bus.memwb_rd       = '0;
    bus.exmem_result   = '0;
    bus.memwb_result   = '0;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic src, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] im);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.funct3   = f3;
    bus.funct7_5 = f7;
    bus.alu_src  = src;
    bus.rs1_addr = a1;
    bus.rs2_addr = a2;
    bus.rs1_data = d1;
    bus.rs2_data = d2;
    bus.imm      = im;
  endtask

  task automatic test_reset();
    idle();
    bus.out_ready = 1'b1;
    drive(2'b01, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 8'h12, 8'h34, 8'h56);
    reset = 1'b1;
    tick();
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.data1 !== 8'h00) begin bad++; $display("FAIL reset_data1 got=%h want=00", bus.data1); end
    total++; if (bus.data2 !== 8'h00) begin bad++; $display("FAIL reset_data2 got=%h want=00", bus.data2); end
    total++; if (bus.ALU_control !== 4'b0000) begin bad++; $display("FAIL reset_ctrl got=%b want=0000", bus.ALU_control); end
    total++; if (bus.illegal_op !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", bus.illegal_op); end
    idle();
    reset = 1'b0;
    tick();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_rtype_add();
    bus.out_ready = 1'b1;
    drive(2'b10, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 8'h05, 8'h03, 8'h00);
    tick();
    idle();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b want=1", bus.out_valid); end
    total++; if (bus.ALU_control !== 4'b0010) begin bad++; $display("FAIL add_ctrl got=%b want=0010", bus.ALU_control); end
    total++; if (bus.data1 !== 8'h05) begin bad++; $display("FAIL add_data1 got=%h want=05", bus.data1); end
    total++; if (bus.data2 !== 8'h03) begin bad++; $display("FAIL add_data2 got=%h want=03", bus.data2); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b want=0", bus.out_valid); end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       src;
    logic [7:0] imm;
    logic [3:0] ctrl;
    logic       ill;
  } dvec_t;

  // Back-to-back accepts with out_ready high: every cycle a new result.
  task automatic test_decode();
    dvec_t v [10];
    logic [7:0] d1, d2, e2;
    v[0] = '{2'b01, 3'b000, 1'b0, 1'b0, 8'h00, 4'b0110, 1'b0};
    v[1] = '{2'b10, 3'b111, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
    v[2] = '{2'b11, 3'b110, 1'b0, 1'b1, 8'hF0, 4'b0001, 1'b0};
    v[3] = '{2'b10, 3'b001, 1'b0, 1'b0, 8'h00, 4'b1111, 1'b1};
    v[4] = '{2'b00, 3'b101, 1'b1, 1'b1, 8'h0C, 4'b0010, 1'b0};
    v[5] = '{2'b10, 3'b000, 1'b1, 1'b0, 8'h00, 4'b0110, 1'b0};
    v[6] = '{2'b11, 3'b000, 1'b1, 1'b1, 8'h7F, 4'b0010, 1'b0};
    v[7] = '{2'b11, 3'b101, 1'b0, 1'b1, 8'h01, 4'b1111, 1'b1};
    v[8] = '{2'b10, 3'b110, 1'b0, 1'b0, 8'h00, 4'b0001, 1'b0};
    v[9] = '{2'b11, 3'b111, 1'b0, 1'b1, 8'h3C, 4'b0000, 1'b0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d1 = 8'h10 + 8'(i);
      d2 = 8'h20 + 8'(i);
      e2 = v[i].src ? v[i].imm : d2;
      drive(v[i].op, v[i].f3, v[i].f7, v[i].src, 5'd1, 5'd2, d1, d2, v[i].imm);
      tick();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL dec%0d_valid got=%b want=1", i, bus.out_valid); end
      total++; if (bus.ALU_control !== v[i].ctrl) begin bad++; $display("FAIL dec%0d_ctrl got=%b want=%b", i, bus.ALU_control, v[i].ctrl); end
      total++; if (bus.illegal_op !== v[i].ill) begin bad++; $display("FAIL dec%0d_illegal got=%b want=%b", i, bus.illegal_op, v[i].ill); end
      total++; if (bus.data1 !== d1) begin bad++; $display("FAIL dec%0d_data1 got=%h want=%h", i, bus.data1, d1); end
      total++; if (bus.data2 !== e2) begin bad++; $display("FAIL dec%0d_data2 got=%h want=%h", i, bus.data2, e2); end
    end
    idle();
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL dec_drain got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_forwarding();
    bus.out_ready = 1'b1;
    // EX/MEM beats MEM/WB.
    drive(2'b10, 3'b000, 1'b0, 1'b0, 5'd5, 5'd2, 8'h11, 8'h22, 8'h00);
    bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd5; bus.exmem_result = 8'hAA;
    bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd5; bus.memwb_result = 8'hBB;
    tick();
    total++; if (bus.data1 !== (FwdOn ? 8'hAA : 8'h11)) begin bad++; $display("FAIL fwd_exmem got=%h want=%h", bus.data1, FwdOn ? 8'hAA : 8'h11); end
    total++; if (bus.data2 !== 8'h22) begin bad++; $display("FAIL fwd_nomatch_rs2 got=%h want=22", bus.data2); end
    // EX/MEM not writing -> MEM/WB.
    bus.exmem_regwrite = 1'b0;
    tick();
    total++; if (bus.data1 !== (FwdOn ? 8'hBB : 8'h11)) begin bad++; $display("FAIL fwd_memwb got=%h want=%h", bus.data1, FwdOn ? 8'hBB : 8'h11); end
    // x0 is never forwarded.
    bus.rs1_addr = 5'd0;
    bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd0;
    bus.memwb_rd = 5'd0;
    tick();
    total++; if (bus.data1 !== 8'h11) begin bad++; $display("FAIL fwd_x0 got=%h want=11", bus.data1); end
    // rs2 path, EX/MEM priority.
    drive(2'b10, 3'b000, 1'b0, 1'b0, 5'd3, 5'd7, 8'h33, 8'h22, 8'h5A);
    bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd7; bus.exmem_result = 8'hCC;
    bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd7; bus.memwb_result = 8'hDD;
    tick();
    total++; if (bus.data2 !== (FwdOn ? 8'hCC : 8'h22)) begin bad++; $display("FAIL fwd_rs2_exmem got=%h want=%h", bus.data2, FwdOn ? 8'hCC : 8'h22); end
    total++; if (bus.data1 !== 8'h33) begin bad++; $display("FAIL fwd_rs1_nomatch got=%h want=33", bus.data1); end
    // Immediate overrides forwarding.
    bus.alu_src = 1'b1;
    tick();
    total++; if (bus.data2 !== 8'h5A) begin bad++; $display("FAIL fwd_imm got=%h want=5A", bus.data2); end
    // rs2 from MEM/WB only.
    bus.alu_src = 1'b0;
    bus.exmem_rd = 5'd9;
    tick();
    total++; if (bus.data2 !== (FwdOn ? 8'hDD : 8'h22)) begin bad++; $display("FAIL fwd_rs2_memwb got=%h want=%h", bus.data2, FwdOn ? 8'hDD : 8'h22); end
    idle();
    tick();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(2'b00, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 8'hA1, 8'hA2, 8'h00);
    tick();
    total++; if (bus.out_valid !== 1'b1 || bus.data1 !== 8'hA1) begin bad++; $display("FAIL bp_A_out got=%b/%h want=1/A1", bus.out_valid, bus.data1); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_A got=%b want=1", bus.in_ready); end
    drive(2'b01, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 8'hB1, 8'hB2, 8'h00);
    tick();
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_B got=%b want=0", bus.in_ready); end
    total++; if (bus.data1 !== 8'hA1 || bus.ALU_control !== 4'b0010) begin bad++; $display("FAIL bp_hold got=%h/%b want=A1/0010", bus.data1, bus.ALU_control); end
    // C is offered while not ready and must not be taken.
    drive(2'b10, 3'b111, 1'b0, 1'b0, 5'd1, 5'd2, 8'hC1, 8'hC2, 8'h00);
    tick();
    total++; if (bus.data1 !== 8'hA1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold2 got=%h/%b want=A1/0", bus.data1, bus.in_ready); end
    idle();
    bus.out_ready = 1'b1;
    tick();
    total++; if (bus.out_valid !== 1'b1 || bus.data1 !== 8'hB1) begin bad++; $display("FAIL bp_B_out got=%b/%h want=1/B1", bus.out_valid, bus.data1); end
    total++; if (bus.ALU_control !== 4'b0110) begin bad++; $display("FAIL bp_B_ctrl got=%b want=0110", bus.ALU_control); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b want=1", bus.in_ready); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(2'b00, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 8'hD1, 8'hD2, 8'h00);
    tick();
    drive(2'b00, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 8'hE1, 8'hE2, 8'h00);
    tick();
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_full got=%b want=0", bus.in_ready); end
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(2'b00, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 8'hF1, 8'hF2, 8'h00);
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", bus.in_ready); end
    idle();
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_gone got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    bus.out_ready = 1'b0;
    drive(2'b01, 3'b000, 1'b0, 1'b1, 5'd1, 5'd2, 8'h71, 8'h72, 8'h73);
    tick();
    drive(2'b01, 3'b000, 1'b0, 1'b1, 5'd1, 5'd2, 8'h81, 8'h82, 8'h83);
    tick();
    idle();
    reset = 1'b1;
    bus.flush = 1'b1;
    tick();
    total++; if (bus.out_valid !== 1'b0 || bus.data1 !== 8'h00 || bus.data2 !== 8'h00) begin bad++; $display("FAIL rst_stall_out got=%b/%h/%h want=0/00/00", bus.out_valid, bus.data1, bus.data2); end
    total++; if (bus.ALU_control !== 4'b0000 || bus.illegal_op !== 1'b0) begin bad++; $display("FAIL rst_stall_ctrl got=%b/%b want=0000/0", bus.ALU_control, bus.illegal_op); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_stall_ready got=%b want=1", bus.in_ready); end
    reset = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(2'b10, 3'b110, 1'b0, 1'b0, 5'd1, 5'd2, 8'h91, 8'h92, 8'h00);
    tick();
    idle();
    total++; if (bus.out_valid !== 1'b1 || bus.data1 !== 8'h91 || bus.ALU_control !== 4'b0001) begin bad++; $display("FAIL rst_first got=%b/%h/%b want=1/91/0001", bus.out_valid, bus.data1, bus.ALU_control); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_no_old got=%b want=0", bus.out_valid); end
  endtask

  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b0;
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
    idle();
    test_reset();
    test_rtype_add();
    test_decode();
    test_forwarding();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
